// File: rtl/system86_pkg.sv
// rtl/system86_pkg.sv - shared widths, offset map and layer register type for the scroll latch bank
package system86_pkg;

  localparam int SCROLLX_W = 9;
  localparam int SCROLLY_W = 8;
  localparam int PRIO_W    = 3;

  // Sub-offsets within a layer slot; A[2] selects the odd layer of the group.
  localparam logic [1:0] OFS_XHI_PRIO = 2'd0;
  localparam logic [1:0] OFS_XLO      = 2'd1;
  localparam logic [1:0] OFS_Y        = 2'd2;
  localparam logic [1:0] OFS_BANK     = 2'd3;

  typedef struct packed {
    logic [SCROLLX_W-1:0] scrollx;
    logic [SCROLLY_W-1:0] scrolly;
    logic [PRIO_W-1:0]    prio;
  } layer_regs_t;

  // Returns the layer registers after a write at the given sub-offset.
  // Sub-offset 3 never touches a layer (bank on even half, ignored on odd half).
  function automatic layer_regs_t layer_write(input layer_regs_t cur,
                                              input logic [1:0] sub,
                                              input logic [7:0] data);
    layer_regs_t r;
    r = cur;
    case (sub)
      OFS_XHI_PRIO: begin
        r.scrollx[SCROLLX_W-1] = data[0];
        r.prio                 = data[7:5];
      end
      OFS_XLO: r.scrollx[7:0] = data;
      OFS_Y:   r.scrolly      = data;
      default: r = cur;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/scroll_latch_group.sv
// rtl/scroll_latch_group.sv - two layer register sets plus one ROM bank register for one strobe group
module scroll_latch_group
  import system86_pkg::*;
#(
  parameter int BANK_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  commit,
  input  logic [2:0]            ofs,
  input  logic [7:0]            data,
  output layer_regs_t           layer_lo,
  output layer_regs_t           layer_hi,
  output logic [BANK_WIDTH-1:0] bank
);

  // Decode the offset of a committed write into the even layer, odd layer or bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      layer_lo <= '0;
      layer_hi <= '0;
      bank     <= '0;
    end else if (commit) begin
      if (ofs[2]) begin
        layer_hi <= layer_write(layer_hi, ofs[1:0], data);
      end else if (ofs[1:0] == OFS_BANK) begin
        bank <= data[BANK_WIDTH-1:0];
      end else begin
        layer_lo <= layer_write(layer_lo, ofs[1:0], data);
      end
    end
  end

endmodule

// File: rtl/scroll_latch_bank.sv
// rtl/scroll_latch_bank.sv - sub-CPU scroll/priority/bank latches; SCROLL_VBLANK_SHADOW_EN adds vblank-shadowed outputs
module scroll_latch_bank
  import system86_pkg::*;
#(
  parameter int LAYERS     = 4,
  parameter int BANK_WIDTH = 5
) (
  input  logic                          CLK_6M,
  input  logic                          rst,
  input  logic                          SE,
  input  logic                          nVBLK,
  input  logic                          nLTH0,
  input  logic                          nLTH1,
  input  logic [2:0]                    A,
  input  logic [7:0]                    D,
  output logic [LAYERS*SCROLLX_W-1:0]   SCROLLX,
  output logic [LAYERS*SCROLLY_W-1:0]   SCROLLY,
  output logic [LAYERS*PRIO_W-1:0]      PRIO,
  output logic [BANK_WIDTH-1:0]         BANK0,
  output logic [BANK_WIDTH-1:0]         BANK1
);

  logic       se_s1, se_s2;
  logic       nlth0_s1, nlth0_s2;
  logic       nlth1_s1, nlth1_s2;
  logic [2:0] a_s1, a_s2;
  logic [7:0] d_s1, d_s2;

  logic       e_fall;
  logic       commit0, commit1;
  logic [2:0] commit_ofs;
  logic [7:0] commit_data;

  layer_regs_t lyr   [LAYERS];
  layer_regs_t shown [LAYERS];

  // Two-stage capture of the asynchronous sub-CPU bus into the pixel clock domain.
  always_ff @(posedge CLK_6M or posedge rst) begin
    if (rst) begin
      se_s1    <= 1'b0;
      se_s2    <= 1'b0;
      nlth0_s1 <= 1'b0;
      nlth0_s2 <= 1'b0;
      nlth1_s1 <= 1'b0;
      nlth1_s2 <= 1'b0;
      a_s1     <= '0;
      a_s2     <= '0;
      d_s1     <= '0;
      d_s2     <= '0;
    end else begin
      se_s1    <= SE;
      se_s2    <= se_s1;
      nlth0_s1 <= nLTH0;
      nlth0_s2 <= nlth0_s1;
      nlth1_s1 <= nLTH1;
      nlth1_s2 <= nlth1_s1;
      a_s1     <= A;
      a_s2     <= a_s1;
      d_s1     <= D;
      d_s2     <= d_s1;
    end
  end

  // s2 still holds the last high-E sample of strobe, address and data when the fall shows up.
  assign e_fall = se_s2 & ~se_s1;

  // Register the fall detect together with the bus contents so the groups update one edge later.
  always_ff @(posedge CLK_6M or posedge rst) begin
    if (rst) begin
      commit0     <= 1'b0;
      commit1     <= 1'b0;
      commit_ofs  <= '0;
      commit_data <= '0;
    end else begin
      commit0     <= e_fall & ~nlth0_s2;
      commit1     <= e_fall & ~nlth1_s2;
      commit_ofs  <= a_s2;
      commit_data <= d_s2;
    end
  end

  scroll_latch_group #(.BANK_WIDTH(BANK_WIDTH)) u_grp0 (
    .clk      (CLK_6M),
    .rst      (rst),
    .commit   (commit0),
    .ofs      (commit_ofs),
    .data     (commit_data),
    .layer_lo (lyr[0]),
    .layer_hi (lyr[1]),
    .bank     (BANK0)
  );

  scroll_latch_group #(.BANK_WIDTH(BANK_WIDTH)) u_grp1 (
    .clk      (CLK_6M),
    .rst      (rst),
    .commit   (commit1),
    .ofs      (commit_ofs),
    .data     (commit_data),
    .layer_lo (lyr[2]),
    .layer_hi (lyr[3]),
    .bank     (BANK1)
  );

`ifdef SCROLL_VBLANK_SHADOW_EN
  logic nvblk_s1, nvblk_s2;
  logic vblank_load;

  // Sample vblank and register its falling edge as the shadow load strobe.
  always_ff @(posedge CLK_6M or posedge rst) begin
    if (rst) begin
      nvblk_s1    <= 1'b0;
      nvblk_s2    <= 1'b0;
      vblank_load <= 1'b0;
    end else begin
      nvblk_s1    <= nVBLK;
      nvblk_s2    <= nvblk_s1;
      vblank_load <= nvblk_s2 & ~nvblk_s1;
    end
  end

  // Copy staged scroll/priority to the visible registers once per vblank.
  always_ff @(posedge CLK_6M or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAYERS; i++) shown[i] <= '0;
    end else if (vblank_load) begin
      for (int i = 0; i < LAYERS; i++) shown[i] <= lyr[i];
    end
  end
`else
  logic unused_nvblk;
  assign unused_nvblk = nVBLK;

  // Without shadowing the commit registers drive the tilemap generators directly.
  always_comb begin
    for (int i = 0; i < LAYERS; i++) shown[i] = lyr[i];
  end
`endif

  // Pack per-layer registers into the flat output buses, layer 0 in the low bits.
  always_comb begin
    SCROLLX = '0;
    SCROLLY = '0;
    PRIO    = '0;
    for (int i = 0; i < LAYERS; i++) begin
      SCROLLX[i*SCROLLX_W +: SCROLLX_W] = shown[i].scrollx;
      SCROLLY[i*SCROLLY_W +: SCROLLY_W] = shown[i].scrolly;
      PRIO[i*PRIO_W +: PRIO_W]          = shown[i].prio;
    end
  end

endmodule

// File: doc/scroll_latch_bank.md
# scroll_latch_bank

Scroll, priority and ROM-bank register file for the four tilemap layers, written by the sub CPU through the `nLTH0` and `nLTH1` strobes that the sub-CPU address decoder produces. The block sits downstream of that decoder on the shared sub-CPU data bus. It registers writes on the falling edge of the sub-CPU E clock and presents stable per-layer scroll X/Y, priority and ROM bank values to the tilemap generators and the program-ROM bank logic.

## Interface
- `LAYERS`, 4: number of tilemap layers. Fixed at two groups of two.
- `BANK_WIDTH`, 5: width of each ROM bank register.
- `CLK_6M` in 1: pixel clock; every flop in the block uses its rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `SE` in 1: sub-CPU E clock (level).
- `nVBLK` in 1: vertical blank, active-low.
- `nLTH0` in 1: active-low select for group 0 (layers 0/1, 0x9000–0x93FF).
- `nLTH1` in 1: active-low select for group 1 (layers 2/3, 0x9400–0x97FF).
- `A` in 3: sub-CPU address bits [2:0].
- `D` in 8: sub-CPU write data.
- `SCROLLX` out 4×9: per-layer horizontal scroll.
- `SCROLLY` out 4×8: per-layer vertical scroll.
- `PRIO` out 4×3: per-layer priority.
- `BANK0` out BANK_WIDTH: ROM 9D bank select (group 0, offset 3).
- `BANK1` out BANK_WIDTH: ROM 12D bank select (group 1, offset 3).

## Operation
- Input stage: `SE`, `nLTH0`, `nLTH1`, `A` and `D` are registered every cycle (s1), then registered again (s2).
- Write commit fires when `SE_s2`=1, `SE_s1`=0 and `nLTHx_s2`=0. The commit uses `A_s2` and `D_s2`, which were sampled during the last high cycle of E.
- If both `nLTH0_s2` and `nLTH1_s2` are 0 (illegal), both groups commit the same write.
- Offset map within a group. Layer n is 2g for offsets 0–2 and 2g+1 for offsets 4–6:
  - Offset 0/4: `D[0]` goes to `SCROLLX[8]`; `D[7:5]` goes to `PRIO`. `D[4:1]` is ignored.
  - Offset 1/5: `D` goes to `SCROLLX[7:0]`.
  - Offset 2/6: `D` goes to `SCROLLY`.
  - Offset 3: `D[BANK_WIDTH-1:0]` goes to `BANKg`.
  - Offset 7: ignored. No register changes.
- Writing offset 0 updates only bit 8 of `SCROLLX`. Writing offset 1 updates only bits [7:0].
- Reset: every register and every output is 0. `SE_s1`/`SE_s2` reset to 0, so no spurious commit occurs after reset is released.
- Reset asserted mid-write: the pending commit is discarded.

## Timing
- Write latency: an output changes on the third rising `CLK_6M` edge after E is first sampled low.
  - Edge 1 updates s1.
  - Edge 2 updates s2 and detects the fall.
  - Edge 3 updates the register.
- At most one commit per E period. E stays high for at least 2 `CLK_6M` cycles, so every E fall is seen.
- A strobe that is asserted only while E is low produces no commit.
- Bank registers always update immediately, whatever the configuration.

## Configuration
- `SCROLL_VBLANK_SHADOW_EN` defined:
  - Scroll and priority writes go into staging registers.
  - The outputs load from staging on the cycle after a falling edge of `nVBLK` is detected. That edge is registered once, so outputs load 2 edges after `nVBLK` is sampled low.
  - A commit and a shadow load in the same cycle: the load copies the old staging value. The new write appears at the next vblank.
  - Reset clears both staging and output registers.
- `SCROLL_VBLANK_SHADOW_EN` undefined: scroll and priority outputs are the commit registers directly, with no vblank dependency. `nVBLK` is unused.

## Structure
- Shared package `system86_pkg` holds:
  - `SCROLLX_W`=9, `SCROLLY_W`=8, `PRIO_W`=3.
  - The offset constants `OFS_XHI_PRIO`, `OFS_XLO`, `OFS_Y`, `OFS_BANK`.
  - A `layer_regs_t` struct {scrollx, scrolly, prio}.
- Sub-module `scroll_latch_group`: one group holding two layers plus one bank register, with commit enable, offset and data inputs. It is instantiated twice.
- The top level owns the input sync stages, the E-fall and vblank-edge detection, and the output packing.

## Test plan
- Reset, then release with the bus idle: all outputs read 0 for 100 cycles.
- With `nLTH0`=0 and E cycling, write A=1 D=0x34, then A=0 D=0xA1:
  - `SCROLLX[0]`=0x134, `PRIO[0]`=5.
  - Each change lands exactly 3 edges after its E fall.
- With `nLTH1`=0, write A=6 D=0x7F, then A=3 D=0xFF: `SCROLLY[3]`=0x7F and `BANK1`=0x1F. Group 0 is unchanged.
- Write A=7 D=0xFF on both groups, and separately pulse the strobe only while E is low: no output changes.
- With `SCROLL_VBLANK_SHADOW_EN` defined:
  - Write `SCROLLY[1]`=0x40 during active video. The output stays 0 until `nVBLK` falls, then becomes 0x40.
  - A write committing in the same cycle as the shadow load appears only at the following vblank.
- Assert `rst` between the E fall and the commit edge of a write of 0x55 to `SCROLLY[2]`: the output stays 0 after release.
